// File: rtl/npc_sequencer_pkg.sv
// npc_seq_pkg: shared FSM states, trap cause codes and default vectors for the PC sequencer.
package npc_seq_pkg;
   typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;
   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_TRAP = 2'd1;
   localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
endpackage

// File: rtl/npc_sequencer_if.sv
// npc_sequencer_if: PC, fetch handshake, execute controls and trap status of the sequencer.
interface npc_sequencer_if;
   logic [31:0] pc_i, npc_o, br_target_i, epc_o, retire_cnt_o;
   logic imem_req_o, imem_ack_i, inst_valid_o, stall_i, br_taken_i, trap_i, mret_i, halt_i;
   logic [1:0] cause_o, state_o;
   modport master (
      input pc_i, imem_ack_i, stall_i, br_taken_i, br_target_i, trap_i, mret_i, halt_i,
      output npc_o, imem_req_o, inst_valid_o, epc_o, cause_o, retire_cnt_o, state_o
   );
   modport slave (
      output pc_i, imem_ack_i, stall_i, br_taken_i, br_target_i, trap_i, mret_i, halt_i,
      input npc_o, imem_req_o, inst_valid_o, epc_o, cause_o, retire_cnt_o, state_o
   );
endinterface

// File: rtl/npc_sel.sv
// npc_sel: EXEC-stage next-PC priority mux; misaligned redirects are turned into traps.
module npc_sel
   import npc_seq_pkg::*;
#(
   parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
   input  logic [31:0] pc,
   input  logic [31:0] epc,
   input  logic        trap,
   input  logic        halt,
   input  logic        mret,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic [31:0] npc,
   output logic        retire,
   output logic        take_trap,
   output logic [1:0]  cause
);
   logic misalign;
   // only the redirect that would actually win is checked for alignment
   assign misalign = !trap && !halt && (mret ? epc[1:0] != 2'b00 : br_taken && br_target[1:0] != 2'b00);
   assign take_trap = trap || misalign;
   assign retire = !take_trap;
   assign cause = trap ? CAUSE_TRAP : misalign ? CAUSE_MISALIGN : CAUSE_NONE;
   assign npc = take_trap ? TRAP_VEC : halt ? pc : mret ? epc : br_taken ? br_target : pc + 32'd4;
endmodule

// File: rtl/npc_sequencer.sv
// npc_sequencer: fetch/execute FSM driving the next PC, with trap/mret/halt handling.
module npc_sequencer
   import npc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
   input logic clk,
   input logic rst,
   npc_sequencer_if.master bus
);
   state_t state;
   logic [31:0] epc, cnt, sel_npc;
   logic [1:0] cause, sel_cause;
   logic retire, take_trap;
   npc_sel #(.TRAP_VEC(TRAP_VEC)) u_sel (
      .pc(bus.pc_i),
      .epc(epc),
      .trap(bus.trap_i),
      .halt(bus.halt_i),
      .mret(bus.mret_i),
      .br_taken(bus.br_taken_i),
      .br_target(bus.br_target_i),
      .npc(sel_npc),
      .retire(retire),
      .take_trap(take_trap),
      .cause(sel_cause)
   );
   // the PC register reloads every clock, so holding means echoing pc_i
   assign bus.npc_o = state == BOOT ? RESET_PC : (state == EXEC && !bus.stall_i) ? sel_npc : bus.pc_i;
   assign bus.imem_req_o = state == FETCH;
   assign bus.inst_valid_o = state == EXEC;
   assign bus.epc_o = epc;
   assign bus.cause_o = cause;
   assign bus.retire_cnt_o = cnt;
   assign bus.state_o = state;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
         epc <= '0;
         cause <= CAUSE_NONE;
         cnt <= '0;
      end else begin
         case (state)
            BOOT: state <= FETCH;
            FETCH: if (bus.imem_ack_i) state <= EXEC;
            EXEC: if (!bus.stall_i) begin
               state <= (retire && bus.halt_i) ? HALT : FETCH;
               if (take_trap) begin
                  epc <= bus.pc_i;
                  cause <= sel_cause;
               end else begin
                  cnt <= cnt + 32'd1;
                  if (bus.mret_i && !bus.halt_i) cause <= CAUSE_NONE;
               end
            end
            default: state <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_npc_sequencer.sv
// tb_npc_sequencer: directed plus randomized instruction sequences checked against an
// instruction-level model of the next-PC rules.
module tb_npc_sequencer;
   localparam logic [31:0] TV = 32'h0000_0100;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [31:0] m_pc, m_epc, m_ret;
   logic [1:0] m_cause;
   npc_sequencer_if bus();
   npc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // external PC register: loads npc unconditionally every clock
   always @(posedge clk) bus.pc_i <= bus.npc_o;
   initial begin
      #500000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic clr();
      bus.imem_ack_i = 1'b0;
      bus.stall_i = 1'b0;
      bus.trap_i = 1'b0;
      bus.halt_i = 1'b0;
      bus.mret_i = 1'b0;
      bus.br_taken_i = 1'b0;
      bus.br_target_i = '0;
   endtask
   // one instruction: fetch with ack delay, stall cycles, then an EXEC decision
   task automatic instr(input int dly, input int stalls, input logic trap, input logic halt,
                        input logic mret, input logic br, input logic [31:0] tgt);
      logic [31:0] exp;
      logic [1:0] exp_state;
      int req_cycles, valid_cycles;
      req_cycles = 0;
      valid_cycles = 0;
      for (int i = 0; i <= dly; i++) begin
         bus.imem_ack_i = (i == dly);
         #1;
         req_cycles += int'(bus.imem_req_o);
         valid_cycles += int'(bus.inst_valid_o);
         chk("fetch_npc", bus.npc_o, m_pc);
         step();
      end
      for (int i = 0; i < stalls; i++) begin
         bus.stall_i = 1'b1;
         bus.imem_ack_i = 1'($urandom);
         bus.trap_i = 1'($urandom);
         bus.mret_i = 1'($urandom);
         bus.halt_i = 1'($urandom);
         bus.br_taken_i = 1'($urandom);
         bus.br_target_i = $urandom;
         #1;
         req_cycles += int'(bus.imem_req_o);
         valid_cycles += int'(bus.inst_valid_o);
         chk("stall_npc", bus.npc_o, m_pc);
         step();
      end
      clr();
      bus.trap_i = trap;
      bus.halt_i = halt;
      bus.mret_i = mret;
      bus.br_taken_i = br;
      bus.br_target_i = tgt;
      #1;
      req_cycles += int'(bus.imem_req_o);
      valid_cycles += int'(bus.inst_valid_o);
      exp_state = 2'd1;
      if (trap) begin
         exp = TV; m_epc = m_pc; m_cause = 2'd1;
      end else if (halt) begin
         exp = m_pc; m_ret++; exp_state = 2'd3;
      end else if (mret && m_epc % 4 == 0) begin
         exp = m_epc; m_cause = 2'd0; m_ret++;
      end else if (!mret && br && tgt % 4 == 0) begin
         exp = tgt; m_ret++;
      end else if (mret || br) begin
         exp = TV; m_epc = m_pc; m_cause = 2'd2;
      end else begin
         exp = m_pc + 32'd4; m_ret++;
      end
      chk("exec_npc", bus.npc_o, exp);
      chk("req_cycles", 32'(req_cycles), 32'(dly + 1));
      chk("valid_cycles", 32'(valid_cycles), 32'(stalls + 1));
      step();
      clr();
      m_pc = exp;
      chk("pc", bus.pc_i, m_pc);
      chk("epc", bus.epc_o, m_epc);
      chk("cause", 32'(bus.cause_o), 32'(m_cause));
      chk("retire_cnt", bus.retire_cnt_o, m_ret);
      chk("state", 32'(bus.state_o), 32'(exp_state));
   endtask
   initial begin
      clr();
      m_pc = 0; m_epc = 0; m_ret = 0; m_cause = 0;
      step();
      step();
      chk("rst_state", 32'(bus.state_o), 32'd0);
      chk("rst_npc", bus.npc_o, 32'd0);
      chk("rst_req", 32'(bus.imem_req_o), 32'd0);
      chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
      chk("rst_epc", bus.epc_o, 32'd0);
      chk("rst_cause", 32'(bus.cause_o), 32'd0);
      chk("rst_cnt", bus.retire_cnt_o, 32'd0);
      rst = 1'b0;
      #1;
      chk("boot_npc", bus.npc_o, 32'd0);
      chk("boot_req", 32'(bus.imem_req_o), 32'd0);
      step();
      instr(0, 0, 0, 0, 0, 0, 0);
      instr(3, 2, 0, 0, 0, 0, 0);
      instr(0, 0, 0, 0, 0, 1, 32'h10);
      instr(0, 0, 0, 0, 0, 1, 32'h40);
      instr(1, 0, 0, 0, 0, 1, 32'h10);
      instr(0, 1, 0, 0, 0, 1, 32'h42);
      instr(0, 0, 0, 0, 0, 1, 32'h20);
      instr(2, 0, 1, 0, 0, 1, 32'h80);
      instr(0, 0, 0, 0, 1, 0, 0);
      instr(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      instr(0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 40; n++) begin
         int r;
         logic [31:0] t;
         r = $urandom_range(0, 9);
         t = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         instr($urandom_range(0, 3), $urandom_range(0, 2), r == 0, 1'b0, r == 1,
               r >= 2 && r <= 5, t);
      end
      instr(0, 0, 0, 0, 0, 1, 32'h8);
      instr(1, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         bus.imem_ack_i = 1'($urandom);
         #1;
         chk("halt_pc", bus.pc_i, 32'h8);
         chk("halt_npc", bus.npc_o, 32'h8);
         chk("halt_req", 32'(bus.imem_req_o), 32'd0);
         chk("halt_valid", 32'(bus.inst_valid_o), 32'd0);
         chk("halt_state", 32'(bus.state_o), 32'd3);
         step();
      end
      rst = 1'b1;
      #1;
      chk("rerst_state", 32'(bus.state_o), 32'd0);
      chk("rerst_npc", bus.npc_o, 32'd0);
      chk("rerst_cnt", bus.retire_cnt_o, 32'd0);
      chk("rerst_epc", bus.epc_o, 32'd0);
      chk("rerst_cause", 32'(bus.cause_o), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/npc_sequencer.md
# npc_sequencer

Multi-cycle controller that sequences the program-counter register of the RISC-V core. It sits between the PC register, the instruction memory and the execute stage. It drives the instruction-fetch handshake and computes the next-PC value every cycle. It also handles branch redirects, traps, `mret` and halt. The PC register loads `npc_o` unconditionally on every clock, so the sequencer holds the PC by returning `pc_i`.

## Interface
- `RESET_PC`, default 32'h0000_0000: boot address, loaded on the first cycle after reset.
- `TRAP_VEC`, default 32'h0000_0100: trap handler entry address.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_i`  in  32  current PC from the PC register; also the fetch address.
- `npc_o`  out  32  next PC, fed to the PC register; combinational from state and inputs.
- `imem_req_o`  out  1  fetch request for address `pc_i`.
- `imem_ack_i`  in  1  fetch complete; the instruction word is valid this cycle.
- `inst_valid_o`  out  1  the fetched instruction is presented to decode/execute.
- `stall_i`  in  1  downstream not ready; hold the current instruction.
- `br_taken_i`  in  1  taken branch/jump. Sampled only in EXEC.
- `br_target_i`  in  32  branch/jump target.
- `trap_i`  in  1  exception raised by the current instruction.
- `mret_i`  in  1  return from trap.
- `halt_i`  in  1  stop fetching until reset.
- `epc_o`  out  32  PC of the trapping instruction; registered.
- `cause_o`  out  2  trap cause: 0 none, 1 external trap, 2 misaligned target. Registered.
- `retire_cnt_o`  out  32  count of retired instructions; registered.
- `state_o`  out  2  FSM state, for debug.

## Operation
- FSM states: BOOT=0, FETCH=1, EXEC=2, HALT=3.
- BOOT
  - Drives `npc_o=RESET_PC`, `imem_req_o=0`.
  - Always moves to FETCH after one cycle.
- FETCH
  - Drives `imem_req_o=1` and `npc_o=pc_i`.
  - `imem_ack_i` may arrive in the same cycle as the request or any later cycle; there is no timeout.
  - On ack, moves to EXEC.
- EXEC, with `stall_i=1`
  - Stays in EXEC with `npc_o=pc_i`.
  - `inst_valid_o` stays 1. All control inputs are ignored.
- EXEC, with `stall_i=0`: `npc_o` is chosen by the first matching rule, highest priority first.
  - `trap_i`: `npc_o=TRAP_VEC`; `epc<=pc_i`; `cause<=1`; next state FETCH. The instruction does not retire.
  - `halt_i`: `npc_o=pc_i`; next state HALT; the instruction retires.
  - `mret_i`: `npc_o=epc_o`; `cause<=0`; next state FETCH; the instruction retires.
  - `br_taken_i`: `npc_o=br_target_i`; next state FETCH; the instruction retires.
  - Otherwise: `npc_o=pc_i+4`, computed mod 2^32 so 32'hFFFF_FFFC wraps to 0; next state FETCH; the instruction retires.
- Misaligned redirect
  - Applies when the `mret_i` or `br_taken_i` target has bits [1:0] not equal to 0.
  - Handled as a trap instead: `npc_o=TRAP_VEC`, `epc<=pc_i`, `cause<=2`, no retire.
- HALT
  - Drives `npc_o=pc_i`, `imem_req_o=0`, `inst_valid_o=0`.
  - Leaves only on `rst`.
- Retire counter: increments by 1, wrapping mod 2^32, on each retiring EXEC exit.

## Timing
- Reset values while `rst=1`
  - State BOOT; `npc_o=RESET_PC`; `imem_req_o=0`; `inst_valid_o=0`.
  - `epc_o=0`; `cause_o=0`; `retire_cnt_o=0`; `state_o=0`.
- Assertion of `rst` mid-fetch or mid-EXEC aborts the operation immediately. An outstanding ack is dropped and no counters update.
- Best-case latency is 3 cycles per instruction: FETCH with same-cycle ack, EXEC, then the new PC is visible in the next FETCH.
- Each stall cycle adds 1 cycle. Each ack wait cycle adds 1 cycle.
- `inst_valid_o` is high exactly while in EXEC.
- `imem_req_o` is high exactly while in FETCH.
- `imem_ack_i` outside FETCH is ignored.
- `npc_o` depends combinationally on `pc_i` and the EXEC inputs. There is no combinational path from `imem_ack_i` to `npc_o`.

## Structure
- Package `npc_seq_pkg` holds:
  - the state enum (BOOT, FETCH, EXEC, HALT);
  - the cause constants (CAUSE_NONE, CAUSE_TRAP, CAUSE_MISALIGN);
  - default values for RESET_PC and TRAP_VEC.
- Sub-module `npc_sel`: combinational priority mux plus misalignment check. Inputs are the EXEC controls, `pc_i` and `epc`. Outputs are `npc`, `retire`, `take_trap` and `cause`.
- The FSM, epc/cause registers and retire counter stay in the top-level module.

## Test plan
- Reset release, ack on the first FETCH cycle:
  - `npc_o`=0 in BOOT; `imem_req_o`=1 in the next cycle; `inst_valid_o` the cycle after.
  - With no controls asserted, `npc_o`=4 and `retire_cnt_o` becomes 1.
- `imem_ack_i` delayed 3 cycles, `stall_i` held 2 cycles in EXEC:
  - `imem_req_o` is high for 4 cycles; `npc_o=pc_i` throughout.
  - `inst_valid_o` is high for 3 cycles; exactly 1 retire.
- `br_taken_i` with target 32'h40 at PC 32'h10 -> `npc_o`=32'h40.
- `br_taken_i` with target 32'h42 at PC 32'h10 -> `npc_o`=TRAP_VEC, `epc_o`=32'h10, `cause_o`=2, no retire.
- `trap_i` and `br_taken_i` together at PC 32'h20, then `mret_i` at the handler:
  - On the trap: `npc_o`=32'h100, `epc_o`=32'h20, `cause_o`=1.
  - On `mret_i`: `npc_o`=32'h20, `cause_o`=0.
- `halt_i` at PC 32'h8 -> `state_o`=3; PC frozen at 8 and `imem_req_o`=0 for 10 cycles. Asserting `rst` during HALT returns `state_o`=0, `npc_o`=0 and `retire_cnt_o`=0.
